// File: rtl/magma_decrypt.sv
// ---------------------------------------------------------------------------
// magma_decrypt
//   Iterative GOST R 34.12-2015 "Magma" 64-bit block decryptor with a
//   256-bit key. It is the inverse of the magma encryptor and uses the same
//   start/done handshake, so the two can be swapped in a datapath.
//
//   The key and block are captured when a run starts. After that, the inputs
//   may change without affecting the block in flight. UNROLL Feistel rounds
//   are evaluated per clock, so a block takes 32/UNROLL clocks.
//
// Parameters
//   UNROLL    rounds per clock: 1, 2, 4 or 8. Other values stop elaboration.
//
// Ports
//   clk       clock; all state changes on its rising edge
//   reset_    asynchronous reset, active low
//   start     request; sampled only while busy is low
//   data_in   ciphertext; [63:32] = left half a1, [31:0] = right half a0
//   key       256-bit key; K1 = key[255:224] ... K8 = key[31:0]
//   data_out  plaintext; valid while done is high, held until the next completion
//   done      one-cycle completion pulse
//   busy      high while a block is being processed
// ---------------------------------------------------------------------------
module magma_decrypt #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         start,
  input  logic [63:0]  data_in,
  input  logic [255:0] key,
  output logic [63:0]  data_out,
  output logic         done,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : gBadUnroll
    $error("magma_decrypt: UNROLL must be 1, 2, 4 or 8");
  end

  localparam int       STEPS = 32 / UNROLL;
  localparam logic [4:0] LAST = 5'(STEPS - 1);

  // The GOST R 34.12-2015 substitution tables. Row i is applied to nibble i
  // of the word, where nibble 0 is the least significant nibble.
  localparam logic [3:0] PI [8][16] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  left_q, left_d;
  logic [31:0]  right_q, right_d;
  logic [255:0] keyReg_q, keyReg_d;
  logic [63:0]  dataOut_q, dataOut_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [31:0]  leftRnd, rightRnd, roundKey, newRight;
  logic [4:0]   rnd;
  logic [2:0]   keyIdx;

  // Round function: add the key modulo 2^32, substitute each nibble, then
  // rotate left by 11 bits.
  function automatic logic [31:0] gFunc(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] sum;
    logic [31:0] sub;
    sum = x + k;
    sub = '0;
    for (int i = 0; i < 8; i++) begin
      sub[4*i +: 4] = PI[i][sum[4*i +: 4]];
    end
    return {sub[20:0], sub[31:21]};
  endfunction

  // UNROLL chained rounds starting at round cnt*UNROLL.
  // The decryption key order is K1..K8 for rounds 0-7. Rounds 8-31 then cycle
  // through K8..K1, which gives a key index of 7 - (r % 8); that equals the
  // bitwise inverse of the low three bits of r.
  always_comb begin
    leftRnd  = left_q;
    rightRnd = right_q;
    rnd      = '0;
    keyIdx   = '0;
    roundKey = '0;
    newRight = '0;
    for (int u = 0; u < UNROLL; u++) begin
      rnd      = 5'(int'(cnt_q) * UNROLL + u);
      keyIdx   = (rnd < 5'd8) ? rnd[2:0] : ~rnd[2:0];
      roundKey = keyReg_q[32*(7 - int'(keyIdx)) +: 32];
      newRight = leftRnd ^ gFunc(rightRnd, roundKey);
      leftRnd  = rightRnd;
      rightRnd = newRight;
    end
  end

  // Next-state logic. The block loads in IDLE and the rounds advance in RUN.
  // The final halves go out unswapped as {R, L}. Because the FSM is already
  // back in IDLE during the done cycle, a start in that cycle is accepted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    right_d   = right_q;
    keyReg_d  = keyReg_q;
    dataOut_d = dataOut_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          left_d   = data_in[63:32];
          right_d  = data_in[31:0];
          keyReg_d = key;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        left_d  = leftRnd;
        right_d = rightRnd;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          cnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          dataOut_d = {rightRnd, leftRnd};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. A reset aborts any block in flight immediately.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      keyReg_q  <= '0;
      dataOut_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      right_q   <= right_d;
      keyReg_q  <= keyReg_d;
      dataOut_q <= dataOut_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out = dataOut_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_magma_decrypt.sv
// ---------------------------------------------------------------------------
// tb_magma_decrypt
//   Self-checking bench for magma_decrypt. It instantiates UNROLL=1 (index 0)
//   and UNROLL=4 (index 1) side by side. Expected plaintexts come either from
//   the published GOST vector or from an encryptor model in this file that
//   follows the textbook G/G* round description.
// ---------------------------------------------------------------------------
module tb_magma_decrypt;

  logic         clk = 1'b0;
  logic         reset_;
  logic         startS [2];
  logic [63:0]  dinS   [2];
  logic [255:0] keyS   [2];
  logic [63:0]  doutS  [2];
  logic         doneS  [2];
  logic         busyS  [2];

  int compared   = 0;
  int mismatched = 0;

  localparam logic [255:0] GOST_KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] GOST_CT = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0] GOST_PT = 64'hfedcba9876543210;

  // Each S-box row is written as one hex word, with the entry for input 0 in
  // the top nibble.
  localparam logic [63:0] SB [8] = '{
    64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
  };

  typedef struct {
    logic [255:0] key;
    logic [63:0]  din;
    logic [63:0]  expPt;
  } vec_t;

  magma_decrypt #(.UNROLL(1)) dut1 (
    .clk(clk), .reset_(reset_), .start(startS[0]), .data_in(dinS[0]), .key(keyS[0]),
    .data_out(doutS[0]), .done(doneS[0]), .busy(busyS[0])
  );

  magma_decrypt #(.UNROLL(4)) dut4 (
    .clk(clk), .reset_(reset_), .start(startS[1]), .data_in(dinS[1]), .key(keyS[1]),
    .data_out(doutS[1]), .done(doneS[1]), .busy(busyS[1])
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refG(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [63:0] row;
    s = a + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      row = SB[i];
      t[4*i +: 4] = row[63 - 4*int'(s[4*i +: 4]) -: 4];
    end
    return (t << 11) | (t >> 21);
  endfunction

  // Magma encryption. The key sequence is K1..K8 three times, then K8..K1.
  // There are 31 swapping rounds G, followed by a final G* without the swap.
  function automatic logic [63:0] refEncrypt(input logic [255:0] k, input logic [63:0] blk);
    logic [31:0] sub [8];
    logic [31:0] ks [32];
    logic [31:0] a1, a0, t;
    for (int j = 0; j < 8; j++) sub[j] = k[255 - 32*j -: 32];
    for (int i = 0; i < 32; i++) ks[i] = (i < 24) ? sub[i % 8] : sub[7 - (i % 8)];
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 31; i++) begin
      t  = refG(a0, ks[i]) ^ a1;
      a1 = a0;
      a0 = t;
    end
    return {refG(a0, ks[31]) ^ a1, a0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Pulses start for one clock. The task returns on the falling edge that
  // follows the sampling edge E0.
  task automatic applyStimulus(input int sel, input logic [255:0] k, input logic [63:0] d);
    @(negedge clk);
    startS[sel] = 1'b1;
    keyS[sel]   = k;
    dinS[sel]   = d;
    @(negedge clk);
    startS[sel] = 1'b0;
  endtask

  // Waits a bounded number of cycles for done. If the wait runs out, lat
  // stays at -1. The task can also raise start for one cycle at pokeCycle.
  task automatic waitDone(input int sel, input int pokeCycle, input logic [63:0] pokeData,
                          output logic [63:0] got, output int lat, output int busyCycles);
    lat        = -1;
    got        = 'x;
    busyCycles = busyS[sel] ? 1 : 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == pokeCycle) begin
        startS[sel] = 1'b1;
        dinS[sel]   = pokeData;
      end else if (c == pokeCycle + 1) begin
        startS[sel] = 1'b0;
      end
      if (doneS[sel]) begin
        lat = c;
        got = doutS[sel];
        break;
      end
      if (busyS[sel]) busyCycles++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         vecs [6];
    logic [63:0]  got, got1, got2, pt, ptB;
    logic [255:0] k, kB;
    int           lat, bc, extra, firstDone, secondDone, expLat;
    bit           held;

    reset_ = 1'b0;
    for (int s = 0; s < 2; s++) begin
      startS[s] = 1'b0;
      dinS[s]   = '0;
      keyS[s]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset data_out", doutS[s], 64'h0);
      checkInt("reset done", int'(doneS[s]), 0);
      checkInt("reset busy", int'(busyS[s]), 0);
    end
    reset_ = 1'b1;

    // Fixed vectors: the published GOST vector, plus blocks encrypted by the model.
    vecs[0] = '{GOST_KEY, GOST_CT, GOST_PT};
    vecs[1] = '{256'h0, refEncrypt(256'h0, 64'h0), 64'h0};
    vecs[2] = '{{256{1'b1}}, refEncrypt({256{1'b1}}, {64{1'b1}}), {64{1'b1}}};
    k = 256'h0123456789abcdeffedcba987654321000112233445566778899aabbccddeeff;
    vecs[3] = '{k, refEncrypt(k, 64'h0123456789abcdef), 64'h0123456789abcdef};
    k = {8{32'h5555aaaa}};
    vecs[4] = '{k, refEncrypt(k, 64'haaaa5555aaaa5555), 64'haaaa5555aaaa5555};
    vecs[5] = '{GOST_KEY, refEncrypt(GOST_KEY, 64'h8000000000000001), 64'h8000000000000001};

    for (int s = 0; s < 2; s++) begin
      expLat = (s == 0) ? 32 : 8;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(s, vecs[i].key, vecs[i].din);
        waitDone(s, -1, 64'h0, got, lat, bc);
        checkOutput($sformatf("table[%0d] unroll idx %0d data", i, s), got, vecs[i].expPt);
        checkInt($sformatf("table[%0d] unroll idx %0d latency", i, s), lat, expLat);
      end
    end

    // GOST vector: latency, busy window, and a single-cycle done pulse.
    applyStimulus(0, GOST_KEY, GOST_CT);
    waitDone(0, -1, 64'h0, got, lat, bc);
    checkOutput("gost data", got, GOST_PT);
    checkInt("gost latency", lat, 32);
    checkInt("gost busy cycles", bc, 32);
    @(negedge clk);
    checkInt("gost done width", int'(doneS[0]), 0);
    checkOutput("gost data held", doutS[0], GOST_PT);

    // A start at cycle 10 of the run must be ignored.
    applyStimulus(0, GOST_KEY, GOST_CT);
    waitDone(0, 10, 64'h0, got, lat, bc);
    checkOutput("start-while-busy data", got, GOST_PT);
    checkInt("start-while-busy latency", lat, 32);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (doneS[0]) extra++;
    end
    checkInt("start-while-busy extra done", extra, 0);

    // Input stability: changing key and data after E0 must not matter.
    applyStimulus(0, GOST_KEY, GOST_CT);
    keyS[0] = '0;
    dinS[0] = '1;
    waitDone(0, -1, 64'h0, got, lat, bc);
    checkOutput("input stability data", got, GOST_PT);

    // Reset in the middle of a run.
    applyStimulus(0, GOST_KEY, GOST_CT);
    repeat (15) @(negedge clk);
    #2 reset_ = 1'b0;
    #1;
    checkInt("mid-run reset busy", int'(busyS[0]), 0);
    checkInt("mid-run reset done", int'(doneS[0]), 0);
    checkOutput("mid-run reset data_out", doutS[0], 64'h0);
    @(negedge clk);
    reset_ = 1'b1;
    applyStimulus(0, GOST_KEY, GOST_CT);
    waitDone(0, -1, 64'h0, got, lat, bc);
    checkOutput("after reset data", got, GOST_PT);
    checkInt("after reset latency", lat, 32);

    // Round trip on random key/plaintext pairs, for both unroll factors.
    for (int s = 0; s < 2; s++) begin
      expLat = (s == 0) ? 32 : 8;
      for (int n = 0; n < 1000; n++) begin
        k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt = {$urandom, $urandom};
        applyStimulus(s, k, refEncrypt(k, pt));
        waitDone(s, -1, 64'h0, got, lat, bc);
        checkOutput($sformatf("random[%0d] unroll idx %0d data", n, s), got, pt);
        checkInt($sformatf("random[%0d] unroll idx %0d latency", n, s), lat, expLat);
      end
    end

    // Back-to-back: start held high across two blocks.
    kB  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ptB = {$urandom, $urandom};
    @(negedge clk);
    startS[0] = 1'b1;
    keyS[0]   = GOST_KEY;
    dinS[0]   = GOST_CT;
    @(negedge clk);
    keyS[0]   = kB;
    dinS[0]   = refEncrypt(kB, ptB);
    firstDone  = -1;
    secondDone = -1;
    held       = 1'b1;
    got1       = 'x;
    got2       = 'x;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (doneS[0]) begin
        if (firstDone < 0) begin
          firstDone = c;
          got1      = doutS[0];
        end else begin
          secondDone = c;
          got2       = doutS[0];
          break;
        end
      end else if (firstDone >= 0 && doutS[0] !== got1) begin
        held = 1'b0;
      end
    end
    startS[0] = 1'b0;
    checkInt("back-to-back first latency", firstDone, 32);
    checkInt("back-to-back pulse spacing", secondDone - firstDone, 33);
    checkOutput("back-to-back first data", got1, GOST_PT);
    checkOutput("back-to-back second data", got2, ptB);
    checkInt("back-to-back data held", int'(held), 1);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
